// File: rtl/copperv2_lsu_pkg.sv
// Shared types and helpers for the copperv2 load/store unit.
// Holds access-size and FSM state encodings, byte-strobe base masks and
// the access-legality check used when a command is accepted.
package copperv2_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } size_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    // Byte-enable patterns for a lane-0 access; shifted by the byte offset.
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    // Size 3 is always illegal; misalignment only counts when checking is on.
    function automatic logic access_err(input size_t size, input logic [1:0] addr_lo,
                                        input logic check_align);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_HALF: mis = addr_lo[0];
            SIZE_WORD: mis = |addr_lo;
            default:   mis = 1'b0;
        endcase
        return (size == SIZE_BAD) || (check_align && mis);
    endfunction

endpackage

// File: rtl/copperv2_lsu_if.sv
// Command/response and data-bus (dr read, dw write) signal bundle of the LSU.
// master = LSU side (bus initiator, command target); slave = execute stage
// plus memory responder. All channels are valid/ready.
interface copperv2_lsu_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = 8
);
    // command / response
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [1:0]              cmd_size;
    logic                    cmd_unsigned;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    // data read channel
    logic                    bus_dr_addr_valid;
    logic                    bus_dr_addr_ready;
    logic [ADDR_WIDTH-1:0]   bus_dr_addr_bits;
    logic                    bus_dr_data_valid;
    logic                    bus_dr_data_ready;
    logic [DATA_WIDTH-1:0]   bus_dr_data_bits;
    // data write channel
    logic                    bus_dw_req_valid;
    logic                    bus_dw_req_ready;
    logic [ADDR_WIDTH-1:0]   bus_dw_req_bits_addr;
    logic [DATA_WIDTH-1:0]   bus_dw_req_bits_data;
    logic [STROBE_WIDTH-1:0] bus_dw_req_bits_strobe;
    logic                    bus_dw_resp_valid;
    logic                    bus_dw_resp_ready;
    logic                    bus_dw_resp_bits;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size, cmd_unsigned, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_dr_addr_valid, bus_dr_addr_bits, bus_dr_data_ready,
        input  bus_dr_addr_ready, bus_dr_data_valid, bus_dr_data_bits,
        output bus_dw_req_valid, bus_dw_req_bits_addr, bus_dw_req_bits_data,
        output bus_dw_req_bits_strobe, bus_dw_resp_ready,
        input  bus_dw_req_ready, bus_dw_resp_valid, bus_dw_resp_bits
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size, cmd_unsigned, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_dr_addr_valid, bus_dr_addr_bits, bus_dr_data_ready,
        output bus_dr_addr_ready, bus_dr_data_valid, bus_dr_data_bits,
        input  bus_dw_req_valid, bus_dw_req_bits_addr, bus_dw_req_bits_data,
        input  bus_dw_req_bits_strobe, bus_dw_resp_ready,
        output bus_dw_req_ready, bus_dw_resp_valid, bus_dw_resp_bits
    );

endinterface

// File: rtl/copperv2_lsu_align.sv
// Byte-lane alignment for the LSU: store lane placement + strobes, load extract + extend.
// Latency: purely combinational.
// Backpressure: none; inputs come from registered command state and the read bus.
module copperv2_lsu_align
    import copperv2_lsu_pkg::*;
(
    input  size_t       size,
    input  logic        ld_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data,
    output logic [3:0]  st_strb,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [4:0]  sh;
    logic [31:0] rep;
    logic [31:0] rot;
    logic [31:0] ld_shift;

    always_comb begin
        sh = {addr_lo, 3'b000};

        // Replicate narrow store data into every lane, then rotate so the
        // addressed lanes carry it; aligned cases rotate onto themselves.
        case (size)
            SIZE_BYTE: rep = {4{st_wdata[7:0]}};
            SIZE_HALF: rep = {2{st_wdata[15:0]}};
            default:   rep = st_wdata;
        endcase
        rot = (rep << sh) | (rep >> (6'd32 - {1'b0, sh}));
        st_data = (size == SIZE_BYTE || size == SIZE_HALF) ? rot : (st_wdata << sh);

        case (size)
            SIZE_BYTE: st_strb = STRB_BYTE << addr_lo;
            SIZE_HALF: st_strb = STRB_HALF << addr_lo;
            default:   st_strb = STRB_WORD << addr_lo;
        endcase

        ld_shift = ld_word >> sh;
        case (size)
            SIZE_BYTE: ld_data = ld_unsigned ? {24'd0, ld_shift[7:0]}
                                             : {{24{ld_shift[7]}}, ld_shift[7:0]};
            SIZE_HALF: ld_data = ld_unsigned ? {16'd0, ld_shift[15:0]}
                                             : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default:   ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/copperv2_lsu.sv
// Load/store unit: one command at a time onto the copperv2 dr/dw buses, single response.
// Latency: load/store response 3 cycles after accept with zero-wait bus; errors 1 cycle.
// Backpressure: every valid held with stable bits until its ready; cmd_ready only when idle.
module copperv2_lsu
    import copperv2_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = 8,
    parameter bit CHECK_ALIGN  = 1'b1
) (
    input logic             clk,
    input logic             reset_n,
    copperv2_lsu_if.master  io
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    size_t                 size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [31:0]           st_data;
    logic [3:0]            st_strb;
    logic [31:0]           ld_data;
    logic [ADDR_WIDTH-1:0] addr_word;

    copperv2_lsu_align u_align (
        .size        (size_q),
        .ld_unsigned (uns_q),
        .addr_lo     (addr_q[1:0]),
        .st_wdata    (wdata_q),
        .st_data     (st_data),
        .st_strb     (st_strb),
        .ld_word     (io.bus_dr_data_bits),
        .ld_data     (ld_data)
    );

    assign addr_word = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    // Valids/readies decode registered state only; bus bits are zeroed
    // outside their own state so idle/reset shows a quiet bus.
    assign io.cmd_ready              = (state_q == IDLE);
    assign io.rsp_valid              = (state_q == RESP);
    assign io.rsp_rdata              = rdata_q;
    assign io.rsp_err                = err_q;
    assign io.bus_dr_addr_valid      = (state_q == RD_ADDR);
    assign io.bus_dr_addr_bits       = (state_q == RD_ADDR) ? addr_word : '0;
    assign io.bus_dr_data_ready      = (state_q == RD_DATA);
    assign io.bus_dw_req_valid       = (state_q == WR_REQ);
    assign io.bus_dw_req_bits_addr   = (state_q == WR_REQ) ? addr_word : '0;
    assign io.bus_dw_req_bits_data   = (state_q == WR_REQ) ? st_data : '0;
    assign io.bus_dw_req_bits_strobe = (state_q == WR_REQ)
                                       ? {{(STROBE_WIDTH-4){1'b0}}, st_strb} : '0;
    assign io.bus_dw_resp_ready      = (state_q == WR_RESP);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (io.cmd_valid) begin
                    addr_d  = io.cmd_addr;
                    wdata_d = io.cmd_wdata;
                    size_d  = size_t'(io.cmd_size);
                    uns_d   = io.cmd_unsigned;
                    rdata_d = '0;
                    if (access_err(size_t'(io.cmd_size), io.cmd_addr[1:0], CHECK_ALIGN)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = io.cmd_write ? WR_REQ : RD_ADDR;
                    end
                end
            end
            RD_ADDR: if (io.bus_dr_addr_ready) state_d = RD_DATA;
            RD_DATA: begin
                if (io.bus_dr_data_valid) begin
                    rdata_d = ld_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            WR_REQ:  if (io.bus_dw_req_ready) state_d = WR_RESP;
            WR_RESP: begin
                if (io.bus_dw_resp_valid) begin
                    rdata_d = '0;
                    err_d   = io.bus_dw_resp_bits;
                    state_d = RESP;
                end
            end
            RESP:    if (io.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_copperv2_lsu.sv
// Directed bench for copperv2_lsu: loads, stores, error paths, backpressure, mid-transaction reset.
// Latency: checks exact response cycle counts against a zero-wait responder.
// Backpressure: responder readies/valids driven per-vector from the stimulus.
module tb_copperv2_lsu;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    copperv2_lsu_if lsu_if ();

    copperv2_lsu #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STROBE_WIDTH (8),
        .CHECK_ALIGN  (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (lsu_if)
    );

    int   checks   = 0;
    int   failures = 0;
    logic saw_bus;
    logic multi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // {cmd_ready, rsp_valid, dr_addr_valid, dr_data_ready, dw_req_valid, dw_resp_ready}
    function automatic logic [31:0] vvec();
        return {26'd0, lsu_if.cmd_ready, lsu_if.rsp_valid, lsu_if.bus_dr_addr_valid,
                lsu_if.bus_dr_data_ready, lsu_if.bus_dw_req_valid, lsu_if.bus_dw_resp_ready};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        lsu_if.bus_dr_addr_ready = 1'b1;
        lsu_if.bus_dr_data_valid = 1'b1;
        lsu_if.bus_dr_data_bits  = 32'd0;
        lsu_if.bus_dw_req_ready  = 1'b1;
        lsu_if.bus_dw_resp_valid = 1'b1;
        lsu_if.bus_dw_resp_bits  = 1'b0;
        lsu_if.rsp_ready         = 1'b0;
    endtask

    // Offers one command for one cycle (T0); returns sampled in T1.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
        check("cmd_ready_idle", {31'd0, lsu_if.cmd_ready}, 32'd1);
        lsu_if.cmd_valid    = 1'b1;
        lsu_if.cmd_write    = wr;
        lsu_if.cmd_addr     = addr;
        lsu_if.cmd_wdata    = wdata;
        lsu_if.cmd_size     = size;
        lsu_if.cmd_unsigned = uns;
        step();
        lsu_if.cmd_valid    = 1'b0;
    endtask

    task automatic note_bus();
        if (lsu_if.bus_dr_addr_valid || lsu_if.bus_dw_req_valid) saw_bus = 1'b1;
        if (lsu_if.bus_dr_addr_valid && lsu_if.bus_dw_req_valid) multi = 1'b1;
    endtask

    task automatic wait_rsp(input int max_cycles, output int n);
        n = 0;
        saw_bus = 1'b0;
        multi = 1'b0;
        while (lsu_if.rsp_valid !== 1'b1 && n < max_cycles) begin
            note_bus();
            step();
            n++;
        end
        note_bus();
        if (lsu_if.rsp_valid !== 1'b1) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume();
        lsu_if.rsp_ready = 1'b1;
        step();
        lsu_if.rsp_ready = 1'b0;
    endtask

    task automatic load_test(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] data, input logic [31:0] exp);
        int n;
        lsu_if.bus_dr_data_bits = data;
        issue(1'b0, addr, 32'd0, size, uns);
        check({tag, "_addr"}, lsu_if.bus_dr_addr_bits, addr & 32'hFFFF_FFFC);
        wait_rsp(20, n);
        check({tag, "_lat"}, n, 32'd2);
        check({tag, "_rdata"}, lsu_if.rsp_rdata, exp);
        check({tag, "_err"}, {31'd0, lsu_if.rsp_err}, 32'd0);
        consume();
    endtask

    task automatic store_test(input string tag, input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata, input logic berr,
                              input logic [31:0] exp_data, input logic [7:0] exp_strb);
        int n;
        lsu_if.bus_dw_resp_bits = berr;
        issue(1'b1, addr, wdata, size, 1'b0);
        check({tag, "_valids"}, vvec(), 32'h02);
        check({tag, "_addr"}, lsu_if.bus_dw_req_bits_addr, addr & 32'hFFFF_FFFC);
        check({tag, "_data"}, lsu_if.bus_dw_req_bits_data, exp_data);
        check({tag, "_strb"}, {24'd0, lsu_if.bus_dw_req_bits_strobe}, {24'd0, exp_strb});
        wait_rsp(20, n);
        check({tag, "_lat"}, n, 32'd2);
        check({tag, "_err"}, {31'd0, lsu_if.rsp_err}, {31'd0, berr});
        check({tag, "_rdata"}, lsu_if.rsp_rdata, 32'd0);
        check({tag, "_multi"}, {31'd0, multi}, 32'd0);
        consume();
        lsu_if.bus_dw_resp_bits = 1'b0;
    endtask

    task automatic err_test(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [1:0] size);
        int n;
        issue(wr, addr, 32'hFFFF_FFFF, size, 1'b0);
        wait_rsp(20, n);
        check({tag, "_lat"}, n, 32'd0);
        check({tag, "_err"}, {31'd0, lsu_if.rsp_err}, 32'd1);
        check({tag, "_rdata"}, lsu_if.rsp_rdata, 32'd0);
        check({tag, "_nobus"}, {31'd0, saw_bus}, 32'd0);
        consume();
        check({tag, "_nobus_after"}, vvec(), 32'h20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        reset_n             = 1'b0;
        lsu_if.cmd_valid    = 1'b0;
        lsu_if.cmd_write    = 1'b0;
        lsu_if.cmd_addr     = 32'd0;
        lsu_if.cmd_wdata    = 32'd0;
        lsu_if.cmd_size     = 2'd0;
        lsu_if.cmd_unsigned = 1'b0;
        set_defaults();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valids", vvec(), 32'h20);
        check("rst_rdata", lsu_if.rsp_rdata, 32'd0);
        check("rst_err", {31'd0, lsu_if.rsp_err}, 32'd0);
        check("rst_dr_addr", lsu_if.bus_dr_addr_bits, 32'd0);
        check("rst_dw_addr", lsu_if.bus_dw_req_bits_addr, 32'd0);
        check("rst_dw_data", lsu_if.bus_dw_req_bits_data, 32'd0);
        check("rst_dw_strb", {24'd0, lsu_if.bus_dw_req_bits_strobe}, 32'd0);
        reset_n = 1'b1;
        step();

        // loads, zero-wait responder
        load_test("ld_word",  32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_test("ld_sbyte", 32'h103, 2'd0, 1'b0, 32'h8012_3456, 32'hFFFF_FF80);
        load_test("ld_ubyte", 32'h103, 2'd0, 1'b1, 32'h8012_3456, 32'h0000_0080);
        load_test("ld_uhalf", 32'h102, 2'd1, 1'b1, 32'hBEEF_1234, 32'h0000_BEEF);
        load_test("ld_shalf", 32'h000, 2'd1, 1'b0, 32'h0000_8001, 32'hFFFF_8001);

        // stores
        store_test("st_half", 32'h202, 2'd1, 32'h0000_1234, 1'b1, 32'h1234_1234, 8'h0C);
        store_test("st_byte", 32'h001, 2'd0, 32'h0000_00AB, 1'b0, 32'hABAB_ABAB, 8'h02);
        store_test("st_word", 32'h300, 2'd2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 8'h0F);

        // error paths, no bus activity
        err_test("err_misword", 1'b0, 32'h101, 2'd2);
        err_test("err_size3",   1'b0, 32'h100, 2'd3);
        err_test("err_mishalf", 1'b1, 32'h205, 2'd1);

        // load backpressure; stale data_valid during the address phase is ignored
        lsu_if.bus_dr_addr_ready = 1'b0;
        lsu_if.bus_dr_data_valid = 1'b0;
        issue(1'b0, 32'h104, 32'd0, 2'd2, 1'b0);
        stable = 1'b1;
        repeat (3) begin
            if (!(lsu_if.bus_dr_addr_valid && lsu_if.bus_dr_addr_bits == 32'h104 &&
                  !lsu_if.cmd_ready && !lsu_if.rsp_valid)) stable = 1'b0;
            lsu_if.bus_dr_data_valid = 1'b1;
            lsu_if.bus_dr_data_bits  = 32'hBADB_AD00;
            step();
        end
        check("bp_addr_hold", {31'd0, stable}, 32'd1);
        check("bp_addr_still", vvec(), 32'h08);
        lsu_if.bus_dr_addr_ready = 1'b1;
        step();
        lsu_if.bus_dr_addr_ready = 1'b0;
        lsu_if.bus_dr_data_valid = 1'b0;
        lsu_if.bus_dr_data_bits  = 32'h1122_3344;
        check("bp_rd_data_state", vvec(), 32'h04);
        stable = 1'b1;
        repeat (2) begin
            if (!(lsu_if.bus_dr_data_ready && !lsu_if.rsp_valid && !lsu_if.cmd_ready &&
                  !lsu_if.bus_dr_addr_valid)) stable = 1'b0;
            step();
        end
        check("bp_data_wait", {31'd0, stable}, 32'd1);
        lsu_if.bus_dr_data_valid = 1'b1;
        step();
        lsu_if.bus_dr_data_valid = 1'b0;
        check("bp_rsp_state", vvec(), 32'h10);
        check("bp_rdata", lsu_if.rsp_rdata, 32'h1122_3344);
        stable = 1'b1;
        repeat (2) begin
            if (!(lsu_if.rsp_valid && lsu_if.rsp_rdata == 32'h1122_3344 && !lsu_if.rsp_err &&
                  !lsu_if.cmd_ready)) stable = 1'b0;
            step();
        end
        check("bp_rsp_hold", {31'd0, stable}, 32'd1);
        consume();
        check("bp_back_idle", vvec(), 32'h20);

        // store backpressure
        set_defaults();
        lsu_if.bus_dw_req_ready  = 1'b0;
        lsu_if.bus_dw_resp_valid = 1'b0;
        issue(1'b1, 32'h308, 32'h5566_7788, 2'd2, 1'b0);
        stable = 1'b1;
        repeat (2) begin
            if (!(lsu_if.bus_dw_req_valid && lsu_if.bus_dw_req_bits_addr == 32'h308 &&
                  lsu_if.bus_dw_req_bits_data == 32'h5566_7788 &&
                  lsu_if.bus_dw_req_bits_strobe == 8'h0F && !lsu_if.cmd_ready)) stable = 1'b0;
            step();
        end
        check("bp_wreq_hold", {31'd0, stable}, 32'd1);
        lsu_if.bus_dw_req_ready = 1'b1;
        step();
        check("bp_wresp_state", vvec(), 32'h01);
        step();
        check("bp_wresp_wait", vvec(), 32'h01);
        lsu_if.bus_dw_resp_valid = 1'b1;
        step();
        check("bp_wrsp_state", vvec(), 32'h10);
        check("bp_wrsp_err", {31'd0, lsu_if.rsp_err}, 32'd0);
        consume();

        // reset during RD_DATA abandons the transaction
        set_defaults();
        lsu_if.bus_dr_data_valid = 1'b0;
        issue(1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
        step();
        check("rstmid_in_rd_data", vvec(), 32'h04);
        reset_n = 1'b0;
        #1;
        check("rstmid_valids", vvec(), 32'h20);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        check("rstmid_release", vvec(), 32'h20);
        set_defaults();
        load_test("ld_after_rst", 32'h020, 2'd2, 1'b0, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/copperv2_lsu.md
Name: copperv2_lsu

Overview:
Synthesizable data-bus initiator, i.e. the load/store unit on the CPU side of the copperv2 data-read (dr) and data-write (dw) valid/ready channels. Accepts one load or store command at a time from the execute stage and drives the matching bus transaction. Aligns and extends read data, and returns a single response with read data or an error flag. One outstanding transaction; no pipelining across commands.

Parameters:
ADDR_WIDTH, 32, byte address width on cmd and bus
DATA_WIDTH, 32, bus data width (fixed 32; other values unsupported)
STROBE_WIDTH, 8, width of bus_dw_req_bits_strobe; bits [7:4] always driven 0
CHECK_ALIGN, 1, 1 = misaligned accesses are flagged as errors without a bus access; 0 = low address bits ignored for alignment

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  LSU idle, command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = store, 0 = load
cmd_addr  in  32  byte address
cmd_wdata  in  32  store data, right-justified
cmd_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
cmd_unsigned  in  1  load zero-extends when 1, sign-extends when 0
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  misaligned/illegal size, or bus write error
bus_dr_addr_valid  out  1  read address valid
bus_dr_addr_ready  in  1  read address accepted
bus_dr_addr_bits  out  32  word-aligned read address
bus_dr_data_valid  in  1  read data valid
bus_dr_data_ready  out  1  read data accepted
bus_dr_data_bits  in  32  read word
bus_dw_req_valid  out  1  write request valid
bus_dw_req_ready  in  1  write request accepted
bus_dw_req_bits_addr  out  32  word-aligned write address
bus_dw_req_bits_data  out  32  lane-shifted write data
bus_dw_req_bits_strobe  out  8  byte enables, bits [3:0] used
bus_dw_resp_valid  in  1  write response valid
bus_dw_resp_ready  out  1  write response accepted
bus_dw_resp_bits  in  1  1 = write error

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE.
  - All valid/ready outputs are 0 except cmd_ready = 1.
  - rsp_rdata, rsp_err and all bus bit outputs are 0.
  - Asserting reset mid-transaction drops every valid immediately; the transaction is abandoned with no response.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE:
  - cmd_ready = 1. On accept, latch the command.
  - Error case: cmd_size == 3, or (CHECK_ALIGN and half with addr[0] set, or word with addr[1:0] != 0). Go to RESP with rsp_err = 1 and no bus activity.
  - Otherwise a load goes to RD_ADDR and a store goes to WR_REQ.
- RD_ADDR:
  - bus_dr_addr_valid = 1, bus_dr_addr_bits = {addr[31:2], 2'b00}, held stable until bus_dr_addr_ready.
  - On handshake go to RD_DATA.
- RD_DATA:
  - bus_dr_data_ready = 1 only in this state; a data_valid seen earlier is ignored.
  - On bus_dr_data_valid, capture the word shifted right by addr[1:0]*8.
  - Truncate to size, then sign- or zero-extend into rsp_rdata with rsp_err = 0. Go to RESP.
- WR_REQ:
  - bus_dw_req_valid = 1, address word-aligned.
  - data = cmd_wdata shifted left by addr[1:0]*8, with the byte/half replicated into unused lanes.
  - strobe[3:0] = (byte 4'b0001, half 4'b0011, word 4'b1111) << addr[1:0]; strobe[7:4] = 0.
  - All fields held stable until bus_dw_req_ready; then go to WR_RESP.
- WR_RESP:
  - bus_dw_resp_ready = 1.
  - On bus_dw_resp_valid, rsp_err = bus_dw_resp_bits and rsp_rdata = 0. Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On handshake go to IDLE. A new command is accepted no earlier than the following cycle.
- Latency, zero-wait responder:
  - Load: accept at T0, addr handshake T1, data handshake T2, rsp_valid T3.
  - Store: same timing.
  - Error: rsp_valid at T1.
- Invariants:
  - Never more than one bus valid asserted at a time.
  - No valid is deasserted without its handshake (except on reset).
  - Ready outputs are registered-state decodes with no combinational path from bus inputs.

Decomposition:
- Package copperv2_lsu_pkg holds:
  - size_t enum (SIZE_BYTE/HALF/WORD).
  - state_t enum.
  - strobe base masks.
  - misalign-check function.
- One sub-module, copperv2_lsu_align: purely combinational.
  - Store lane shift and strobe generation.
  - Load lane extract and sign/zero extension.
- The FSM and registers stay in copperv2_lsu.

Test Plan:
- Word load, addr 0x100, responder returns 0xDEADBEEF with zero wait: bus_dr_addr_bits = 0x100, rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid at T3.
- Signed byte load, addr 0x103, data 0x80xxxxxx: rsp_rdata = 0xFFFFFF80. Same with cmd_unsigned = 1: rsp_rdata = 0x00000080.
- Half store, addr 0x202, wdata 0x1234: addr_bits = 0x200, data = 0x12341234, strobe = 0x0C. resp_bits = 1 gives rsp_err = 1.
- Misaligned word load at 0x101 with CHECK_ALIGN = 1: no bus valid ever asserted; rsp_valid with rsp_err = 1 one cycle after accept.
- Backpressure: addr_ready low 3 cycles, data_valid delayed 2 cycles, rsp_ready low 2 cycles. All valids and bits stay stable and cmd_ready stays 0 until rsp_ready.
- reset_n pulled low in RD_DATA: all valids 0 immediately, cmd_ready = 1 after release, and the next command completes normally.
